// File: rtl/clken_nco_multi_if.sv
// Configuration port bundle for clken_nco_multi.
//
// Handshake: a write is taken on a rising edge where cfg_valid && cfg_ready;
// an apply is taken on a rising edge where cfg_apply && cfg_ready. Both may
// fire on the same edge, and the write is then part of the applied set.
// cfg_ready never depends on cfg_valid or cfg_apply. cfg_err is a one-cycle
// response that follows a rejected write.
//
// Signals:
//   cfg_valid  write request          cfg_ready  write/apply can be taken
//   cfg_ch     target channel         cfg_inc    rate numerator
//   cfg_mod    rate denominator       cfg_phase  start accumulator value
//   cfg_apply  commit shadow regs     cfg_err    rejected-write pulse
interface clken_nco_multi_if #(
  parameter int NUM_CH = 8,
  parameter int ACC_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_mod;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_apply;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_mod, cfg_phase, cfg_apply,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_mod, cfg_phase, cfg_apply,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clken_nco_multi.sv
// Multi-channel fractional clock-enable generator.
//
// Each channel runs a modulo accumulator that advances by inc every refclk
// cycle and wraps at mod, giving a single-cycle enable at rate inc/mod.
// Ratios are written into per-channel shadow registers and committed to all
// channels at once by an apply; every accumulator then restarts from its
// programmed phase on the same edge, so channels with equal settings stay
// cycle-aligned. Enables are held off until the lock counter expires.
//
// Ports:
//   refclk     single clock, rising edge
//   rst_n      synchronous active-low reset
//   cfg        configuration port (clken_nco_multi_if slave modport)
//   ce         per-channel registered enable strobes
//   locked     strobes are valid and stable
//   dbg_state  current FSM state (ALIGN=0, COUNT_LOCK=1, LOCKED=2)
module clken_nco_multi #(
  parameter int NUM_CH      = 8,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst_n,
  clken_nco_multi_if.slave  cfg,
  output logic [NUM_CH-1:0] ce,
  output logic              locked,
  output logic [1:0]        dbg_state
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CHX_W = CH_W + 1;
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  localparam logic [CHX_W-1:0] CH_LIMIT = CHX_W'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  localparam logic [1:0] ST_ALIGN  = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]       state, state_n;
  // Cleared by reset so that ALIGN holds for one extra edge after reset,
  // giving reset release the same timing as an accepted apply.
  logic             armed;
  logic [CNT_W-1:0] lock_cnt;
  logic             err_q;

  logic [ACC_W-1:0] sh_inc   [NUM_CH];
  logic [ACC_W-1:0] sh_mod   [NUM_CH];
  logic [ACC_W-1:0] sh_phase [NUM_CH];
  logic [ACC_W-1:0] act_inc  [NUM_CH];
  logic [ACC_W-1:0] act_mod  [NUM_CH];
  logic [ACC_W-1:0] acc      [NUM_CH];
  logic [ACC_W-1:0] acc_next [NUM_CH];
  logic [NUM_CH-1:0] wrap_next, wrap_q;

  logic write_fire, apply_fire, write_legal;

  assign cfg.cfg_ready = rst_n && (state != ST_ALIGN);
  assign cfg.cfg_err   = err_q;
  assign write_fire    = cfg.cfg_valid && cfg.cfg_ready;
  assign apply_fire    = cfg.cfg_apply && cfg.cfg_ready;
  assign locked        = (state == ST_LOCKED);
  assign dbg_state     = state;

  // A legal ratio keeps acc < mod forever, so the accumulator needs only one
  // extra bit for the sum and never more than one subtraction per cycle.
  assign write_legal = (cfg.cfg_mod != '0) &&
                       (cfg.cfg_inc <= cfg.cfg_mod) &&
                       (cfg.cfg_phase < cfg.cfg_mod) &&
                       ({1'b0, cfg.cfg_ch} < CH_LIMIT);

  always_comb begin
    state_n = state;
    case (state)
      ST_ALIGN:  if (armed) state_n = ST_COUNT;
      ST_COUNT: begin
        if (apply_fire)                state_n = ST_ALIGN;
        else if (lock_cnt == CNT_LAST) state_n = ST_LOCKED;
      end
      ST_LOCKED: if (apply_fire) state_n = ST_ALIGN;
      default:   state_n = ST_ALIGN;
    endcase
  end

  always_comb begin
    logic [ACC_W:0] sum;
    wrap_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, acc[i]} + {1'b0, act_inc[i]};
      if (sum >= {1'b0, act_mod[i]}) begin
        acc_next[i]  = ACC_W'(sum - {1'b0, act_mod[i]});
        wrap_next[i] = 1'b1;
      end else begin
        acc_next[i]  = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state    <= ST_ALIGN;
      armed    <= 1'b0;
      lock_cnt <= '0;
      err_q    <= 1'b0;
      wrap_q   <= '0;
      ce       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_inc[i]   <= '0;
        sh_mod[i]   <= ACC_W'(1);
        sh_phase[i] <= '0;
        act_inc[i]  <= '0;
        act_mod[i]  <= ACC_W'(1);
        acc[i]      <= '0;
      end
    end else begin
      state <= state_n;
      armed <= 1'b1;
      err_q <= write_fire && !write_legal;
      // The mask looks at the next state so ce drops on the apply edge and
      // opens on the edge where locked rises.
      ce    <= (state_n == ST_LOCKED) ? wrap_q : '0;

      if (write_fire && write_legal) begin
        sh_inc[cfg.cfg_ch]   <= cfg.cfg_inc;
        sh_mod[cfg.cfg_ch]   <= cfg.cfg_mod;
        sh_phase[cfg.cfg_ch] <= cfg.cfg_phase;
      end

      if (state == ST_ALIGN) begin
        wrap_q <= '0;
        if (armed) begin
          lock_cnt <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            act_inc[i] <= sh_inc[i];
            act_mod[i] <= sh_mod[i];
            acc[i]     <= sh_phase[i];
          end
        end
      end else begin
        wrap_q <= wrap_next;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= acc_next[i];
        if (state == ST_COUNT) lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

endmodule
